// File: rtl/shared_mem_sched_if.sv
// Processor-side bundle of the shared scratchpad burst scheduler.
// Master modport is the processor cluster, slave modport is the scheduler.
interface shared_mem_sched_if #(
    parameter int PORT_COUNT = 4,
    parameter int ADDR_SIZE  = 24,
    parameter int LEN_W      = 4
);
    logic [PORT_COUNT-1:0]           i_req;
    logic [PORT_COUNT-1:0]           i_we;
    logic [PORT_COUNT*ADDR_SIZE-1:0] i_addr;
    logic [PORT_COUNT*LEN_W-1:0]     i_len;
    logic [PORT_COUNT-1:0]           o_grant;
    logic [PORT_COUNT-1:0]           o_beat;
    logic [PORT_COUNT-1:0]           o_rd_valid;
    logic [PORT_COUNT-1:0]           o_done;
    logic [ADDR_SIZE-1:0]            o_mem_addr;
    logic                            o_mem_wr_en;
    logic                            o_busy;

    modport master (
        output i_req, i_we, i_addr, i_len,
        input  o_grant, o_beat, o_rd_valid, o_done,
        input  o_mem_addr, o_mem_wr_en, o_busy
    );

    modport slave (
        input  i_req, i_we, i_addr, i_len,
        output o_grant, o_beat, o_rd_valid, o_done,
        output o_mem_addr, o_mem_wr_en, o_busy
    );
endinterface

// File: rtl/shared_mem_sched.sv
// Round-robin burst scheduler for the shared scratchpad memory.
// One port owns the memory per burst; read returns are tagged by port.
module shared_mem_sched #(
    parameter int PORT_COUNT = 4,
    parameter int ADDR_SIZE  = 24,
    parameter int MEM_SIZE   = 1024,
    parameter int LEN_W      = 4,
    parameter int MEM_LAT    = 1
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    shared_mem_sched_if.slave bus
);
    localparam int IDW = $clog2(PORT_COUNT);
    localparam logic [ADDR_SIZE:0]   MEM_W   = (ADDR_SIZE+1)'(MEM_SIZE);
    localparam logic [ADDR_SIZE-1:0] MEM_A   = ADDR_SIZE'(MEM_SIZE);
    localparam logic [IDW-1:0]       LAST_ID = IDW'(PORT_COUNT - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t state_q, state_d;

    logic [IDW-1:0]        ptr_q, id_q, win;
    logic                  found, we_q, last_beat, rd_push;
    logic [ADDR_SIZE-1:0]  base_q, last_q, base_in, beat_addr;
    logic [ADDR_SIZE:0]    sum;
    logic [LEN_W-1:0]      len_q, cnt_q;
    logic [MEM_LAT-1:0]    pv_q;
    logic [IDW-1:0]        pid_q [MEM_LAT];
    logic [PORT_COUNT-1:0] grant, beat, done, rd_valid;
    logic                  mem_wr_en;
    logic [ADDR_SIZE-1:0]  mem_addr;

    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] p, input int i);
        int s;
        s = int'(p) + i;
        if (s >= PORT_COUNT) s = s - PORT_COUNT;
        return IDW'(s);
    endfunction

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            if (!found && bus.i_req[rr_idx(ptr_q, i)]) begin
                found = 1'b1;
                win   = rr_idx(ptr_q, i);
            end
        end
    end

    // Base is pre-reduced, so one conditional subtract wraps base+beat.
    assign base_in   = bus.i_addr[int'(win)*ADDR_SIZE +: ADDR_SIZE] % MEM_A;
    assign sum       = {1'b0, base_q} + {{(ADDR_SIZE+1-LEN_W){1'b0}}, cnt_q};
    assign beat_addr = (sum >= MEM_W) ? ADDR_SIZE'(sum - MEM_W)
                                      : sum[ADDR_SIZE-1:0];
    assign last_beat = (cnt_q == len_q);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        grant     = '0;
        beat      = '0;
        done      = '0;
        mem_wr_en = 1'b0;
        mem_addr  = last_q;
        rd_push   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) state_d = BURST;
            end
            BURST: begin
                grant[id_q] = 1'b1;
                beat[id_q]  = 1'b1;
                mem_wr_en   = we_q;
                mem_addr    = beat_addr;
                rd_push     = !we_q;
                if (last_beat) begin
                    done[id_q] = 1'b1;
                    state_d    = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            ptr_q  <= '0;
            id_q   <= '0;
            we_q   <= 1'b0;
            base_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            if (state_q == IDLE && found) begin
                id_q   <= win;
                we_q   <= bus.i_we[win];
                base_q <= base_in;
                len_q  <= bus.i_len[int'(win)*LEN_W +: LEN_W];
                cnt_q  <= '0;
            end
            if (state_q == BURST) begin
                last_q <= beat_addr;
                cnt_q  <= cnt_q + 1'b1;
                if (last_beat) ptr_q <= (id_q == LAST_ID) ? '0 : id_q + 1'b1;
            end
        end
    end

    // Read-return tags ride a shift register matching the memory latency.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            pv_q <= '0;
            for (int k = 0; k < MEM_LAT; k++) pid_q[k] <= '0;
        end else begin
            pv_q[0]  <= rd_push;
            pid_q[0] <= id_q;
            for (int k = 1; k < MEM_LAT; k++) begin
                pv_q[k]  <= pv_q[k-1];
                pid_q[k] <= pid_q[k-1];
            end
        end
    end

    always_comb begin
        rd_valid = '0;
        if (pv_q[MEM_LAT-1]) rd_valid[pid_q[MEM_LAT-1]] = 1'b1;
    end

    assign bus.o_grant     = grant;
    assign bus.o_beat      = beat;
    assign bus.o_done      = done;
    assign bus.o_rd_valid  = rd_valid;
    assign bus.o_mem_addr  = mem_addr;
    assign bus.o_mem_wr_en = mem_wr_en;
    assign bus.o_busy      = (state_q == BURST) || (|pv_q);
endmodule

// File: tb/tb_shared_mem_sched.sv
// Bench for shared_mem_sched: directed scenarios plus random traffic
// compared each cycle against a transaction-level model.
module tb_shared_mem_sched;
    localparam int PC = 4;
    localparam int AS = 24;
    localparam int MS = 1024;
    localparam int LW = 4;
    localparam int ML = 2;
    localparam int BW = 4*PC + AS + 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    shared_mem_sched_if #(.PORT_COUNT(PC), .ADDR_SIZE(AS), .LEN_W(LW)) bus();

    shared_mem_sched #(
        .PORT_COUNT(PC), .ADDR_SIZE(AS), .MEM_SIZE(MS),
        .LEN_W(LW), .MEM_LAT(ML)
    ) dut (
        .i_clk (clk),
        .i_rstn(rstn),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [BW-1:0] act;
    logic [BW-1:0] expv;
    assign act = {bus.o_grant, bus.o_beat, bus.o_done, bus.o_rd_valid,
                  bus.o_mem_wr_en, bus.o_mem_addr, bus.o_busy};

    // Transaction model: one active burst, a pointer, and a calendar
    // of read returns keyed by the cycle they must appear in.
    bit m_act = 0;
    int m_id, m_we, m_base, m_len, m_beat, m_p;
    int m_ptr = 0;
    int m_last = 0;
    int m_cyc = 0;
    int rd_at[int];
    logic [PC-1:0] e_g, e_d, e_r;
    logic e_w, e_b;

    always @(posedge clk) begin
        m_cyc++;
        if (!rstn) begin
            m_act  = 0;
            m_ptr  = 0;
            m_last = 0;
            rd_at.delete();
        end else if (m_act) begin
            if (m_we == 0) rd_at[m_cyc - 1 + ML] = m_id;
            if (m_beat == m_len) begin
                m_act = 0;
                m_ptr = (m_id + 1) % PC;
            end else begin
                m_beat++;
            end
        end else begin
            for (int i = 0; i < PC; i++) begin
                m_p = (m_ptr + i) % PC;
                if (!m_act && bus.i_req[m_p]) begin
                    m_act  = 1;
                    m_id   = m_p;
                    m_we   = int'(bus.i_we[m_p]);
                    m_base = int'(bus.i_addr[m_p*AS +: AS]) % MS;
                    m_len  = int'(bus.i_len[m_p*LW +: LW]);
                    m_beat = 0;
                end
            end
        end
        e_g = '0;
        e_d = '0;
        e_r = '0;
        e_w = 1'b0;
        if (m_act) begin
            e_g[m_id] = 1'b1;
            e_w       = (m_we != 0);
            m_last    = (m_base + m_beat) % MS;
            if (m_beat == m_len) e_d[m_id] = 1'b1;
        end
        if (rd_at.exists(m_cyc)) e_r[rd_at[m_cyc]] = 1'b1;
        e_b = m_act || (rd_at.num() > 0);
        if (rd_at.exists(m_cyc)) rd_at.delete(m_cyc);
        expv = {e_g, e_g, e_d, e_r, e_w, AS'(m_last), e_b};
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input bit r, input bit w,
                            input int a, input int l);
        bus.i_req[p]          = r;
        bus.i_we[p]           = w;
        bus.i_addr[p*AS +: AS] = AS'(a);
        bus.i_len[p*LW +: LW]  = LW'(l);
    endtask

    task automatic idle_wait;
        int n;
        n = 0;
        while ((bus.o_busy || bus.o_grant != 0) && n < 40) begin
            tick();
            n++;
        end
        n_cmp++;
        if (bus.o_busy || bus.o_grant != 0) begin
            n_bad++;
            $display("FAIL idle_wait busy=%b grant=%b want idle", bus.o_busy, bus.o_grant);
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (act !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got %h want 0", act);
        end
        rstn = 1'b1;
        tick();
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL reset_release got %h want %h", act, expv);
        end
    endtask

    task automatic test_single_read;
        int first_rv, n_rv;
        first_rv = -1;
        n_rv = 0;
        set_port(2, 1, 0, 'h10, 3);
        for (int k = 0; k < 8; k++) begin
            tick();
            n_cmp++;
            if (act !== expv) begin
                n_bad++;
                $display("FAIL single_bundle k=%0d got %h want %h", k, act, expv);
            end
            if (k == 0) begin
                n_cmp++;
                if (bus.o_grant !== 4'b0100) begin
                    n_bad++;
                    $display("FAIL single_grant got %b want 0100", bus.o_grant);
                end
                set_port(2, 0, 0, 'h10, 3);
            end
            if (k < 4) begin
                n_cmp++;
                if (bus.o_mem_addr !== AS'(16 + k) || bus.o_beat !== 4'b0100) begin
                    n_bad++;
                    $display("FAIL single_addr k=%0d got %h want %h", k, bus.o_mem_addr, 16 + k);
                end
                n_cmp++;
                if (bus.o_done !== ((k == 3) ? 4'b0100 : 4'b0000)) begin
                    n_bad++;
                    $display("FAIL single_done k=%0d got %b", k, bus.o_done);
                end
            end
            if (bus.o_rd_valid == 4'b0100) begin
                n_rv++;
                if (first_rv < 0) first_rv = k;
            end
        end
        n_cmp++;
        if (first_rv != ML || n_rv != 4) begin
            n_bad++;
            $display("FAIL single_rdvalid got first=%0d count=%0d want first=%0d count=4",
                     first_rv, n_rv, ML);
        end
        idle_wait();
    endtask

    task automatic test_round_robin;
        int ids[$];
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        for (int p = 0; p < PC; p++) set_port(p, 1, p[0], p * 'h100, 0);
        for (int k = 0; k < 16; k++) begin
            tick();
            n_cmp++;
            if (act !== expv) begin
                n_bad++;
                $display("FAIL rr_bundle k=%0d got %h want %h", k, act, expv);
            end
            n_cmp++;
            if ((bus.o_grant != 0) != (k % 2 == 0)) begin
                n_bad++;
                $display("FAIL rr_bubble k=%0d grant=%b", k, bus.o_grant);
            end
            for (int p = 0; p < PC; p++) if (bus.o_grant[p]) ids.push_back(p);
        end
        for (int p = 0; p < PC; p++) set_port(p, 0, 0, 0, 0);
        n_cmp++;
        if (ids.size() != 8) begin
            n_bad++;
            $display("FAIL rr_count got %0d want 8", ids.size());
        end
        foreach (ids[i]) begin
            n_cmp++;
            if (ids[i] != i % PC) begin
                n_bad++;
                $display("FAIL rr_order i=%0d got %0d want %0d", i, ids[i], i % PC);
            end
        end
        idle_wait();
    endtask

    task automatic test_wrap;
        int wexp[4] = '{1022, 1023, 0, 1};
        set_port(1, 1, 1, 1022, 3);
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 0) set_port(1, 0, 1, 1022, 3);
            n_cmp++;
            if (act !== expv) begin
                n_bad++;
                $display("FAIL wrap_bundle k=%0d got %h want %h", k, act, expv);
            end
            if (k < 4) begin
                n_cmp++;
                if (bus.o_mem_addr !== AS'(wexp[k]) || bus.o_mem_wr_en !== 1'b1) begin
                    n_bad++;
                    $display("FAIL wrap_addr k=%0d got %0d/%b want %0d/1",
                             k, bus.o_mem_addr, bus.o_mem_wr_en, wexp[k]);
                end
            end
            n_cmp++;
            if (bus.o_rd_valid !== 4'b0000) begin
                n_bad++;
                $display("FAIL wrap_rdvalid k=%0d got %b want 0000", k, bus.o_rd_valid);
            end
        end
        idle_wait();
    endtask

    task automatic test_input_change;
        set_port(0, 1, 0, 'h200, 7);
        for (int k = 0; k < 11; k++) begin
            tick();
            n_cmp++;
            if (act !== expv) begin
                n_bad++;
                $display("FAIL chg_bundle k=%0d got %h want %h", k, act, expv);
            end
            if (k == 3) begin
                set_port(0, 0, 0, 'h300, 7);
                set_port(3, 1, 1, 'h5, 0);
            end
            if (k < 8) begin
                n_cmp++;
                if (bus.o_mem_addr !== AS'('h200 + k) || bus.o_grant !== 4'b0001) begin
                    n_bad++;
                    $display("FAIL chg_addr k=%0d got %h want %h", k, bus.o_mem_addr, 'h200 + k);
                end
            end
            if (k == 7) begin
                n_cmp++;
                if (bus.o_done !== 4'b0001) begin
                    n_bad++;
                    $display("FAIL chg_done got %b want 0001", bus.o_done);
                end
            end
            if (k == 8 || k == 9) begin
                n_cmp++;
                if (bus.o_grant !== ((k == 9) ? 4'b1000 : 4'b0000)) begin
                    n_bad++;
                    $display("FAIL chg_next k=%0d got %b", k, bus.o_grant);
                end
                if (k == 9) set_port(3, 0, 1, 'h5, 0);
            end
        end
        idle_wait();
    endtask

    task automatic test_reset_mid;
        set_port(1, 1, 0, 'h20, 0);
        tick();
        set_port(1, 0, 0, 'h20, 0);
        idle_wait();
        set_port(2, 1, 0, 'h40, 5);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 0) set_port(2, 0, 0, 'h40, 5);
            n_cmp++;
            if (act !== expv) begin
                n_bad++;
                $display("FAIL rstmid_bundle k=%0d got %h want %h", k, act, expv);
            end
        end
        rstn = 1'b0;
        tick();
        n_cmp++;
        if (act !== '0) begin
            n_bad++;
            $display("FAIL rstmid_outputs got %h want 0", act);
        end
        rstn = 1'b1;
        set_port(0, 1, 0, 'h60, 0);
        set_port(3, 1, 0, 'h70, 0);
        tick();
        set_port(0, 0, 0, 'h60, 0);
        set_port(3, 0, 0, 'h70, 0);
        n_cmp++;
        if (bus.o_grant !== 4'b0001 || act !== expv) begin
            n_bad++;
            $display("FAIL rstmid_ptr got %b want 0001", bus.o_grant);
        end
        idle_wait();
    endtask

    task automatic test_back_to_back;
        set_port(1, 1, 0, 'h80, 2);
        set_port(2, 1, 1, 'h90, 1);
        for (int k = 0; k < 8; k++) begin
            tick();
            n_cmp++;
            if (act !== expv) begin
                n_bad++;
                $display("FAIL b2b_bundle k=%0d got %h want %h", k, act, expv);
            end
            if (k == 0) begin
                n_cmp++;
                if (bus.o_grant !== 4'b0010) begin
                    n_bad++;
                    $display("FAIL b2b_first got %b want 0010", bus.o_grant);
                end
                set_port(1, 0, 0, 'h80, 2);
            end
            if (k == 3) begin
                n_cmp++;
                if (bus.o_busy !== 1'b1 || bus.o_grant !== 4'b0000) begin
                    n_bad++;
                    $display("FAIL b2b_bubble busy=%b grant=%b want 1/0000", bus.o_busy, bus.o_grant);
                end
            end
            if (k == 4) begin
                n_cmp++;
                if (bus.o_grant !== 4'b0100 || bus.o_rd_valid !== 4'b0010) begin
                    n_bad++;
                    $display("FAIL b2b_overlap grant=%b rdv=%b want 0100/0010",
                             bus.o_grant, bus.o_rd_valid);
                end
                set_port(2, 0, 1, 'h90, 1);
            end
            if (k == 6) begin
                n_cmp++;
                if (bus.o_busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_drain busy=%b want 0", bus.o_busy);
                end
            end
        end
        idle_wait();
    endtask

    task automatic test_random;
        for (int k = 0; k < 600; k++) begin
            rstn = ($urandom_range(0, 63) != 0);
            bus.i_req = PC'($urandom) & PC'($urandom);
            bus.i_we  = PC'($urandom);
            for (int p = 0; p < PC; p++) begin
                if ($urandom_range(0, 3) == 0)
                    bus.i_addr[p*AS +: AS] = AS'(1008 + $urandom_range(0, 15));
                else
                    bus.i_addr[p*AS +: AS] = AS'($urandom);
            end
            bus.i_len = (PC*LW)'($urandom);
            tick();
            n_cmp++;
            if (act !== expv) begin
                n_bad++;
                $display("FAIL rand_bundle k=%0d got %h want %h", k, act, expv);
            end
        end
        rstn = 1'b1;
        bus.i_req = '0;
        idle_wait();
    endtask

    initial begin
        bus.i_req  = '0;
        bus.i_we   = '0;
        bus.i_addr = '0;
        bus.i_len  = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_wrap();
        test_input_change();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
